// File: rtl/cordic_pkg.sv
// Shared CORDIC constants so the pre-fold, pipe and post stages agree on widths,
// gain and angle units (full turn = 2^AWIDTH).
package cordic_pkg;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_AWIDTH  = 20;
  localparam int unsigned DEF_RES_TOL = 8;
  localparam int unsigned KGAIN_W     = 16;

  // 1/CORDIC gain (0.607253) in unsigned Q0.16
  localparam logic [KGAIN_W-1:0] DEF_KGAIN = 16'h9B75;

  localparam logic [DEF_AWIDTH-1:0] ANG_180 = {1'b1, {(DEF_AWIDTH-1){1'b0}}};
  localparam logic [DEF_AWIDTH-1:0] ANG_90  = {2'b01, {(DEF_AWIDTH-2){1'b0}}};

endpackage

// File: rtl/cordic_gain_mult.sv
// Registered unsigned WIDTH x 16 gain multiply followed by a registered
// round-half-up back to WIDTH bits (post-processing stages 2 and 3).
module cordic_gain_mult
  import cordic_pkg::*;
#(
  parameter int unsigned          WIDTH = DEF_WIDTH,
  parameter logic [KGAIN_W-1:0]   KGAIN = DEF_KGAIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] xabs,
  output logic [WIDTH-1:0] mag
);

  localparam int unsigned PW = WIDTH + KGAIN_W;
  localparam logic [PW-1:0] ROUND = PW'(32'd1 << (KGAIN_W - 1));

  logic [PW-1:0] prod;

  // xabs < 2^(WIDTH-1) and KGAIN < 1.0, so prod + ROUND never carries out of PW bits
  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
      mag  <= '0;
    end else if (ena) begin
      prod <= PW'(xabs) * PW'(KGAIN);
      mag  <= WIDTH'((prod + ROUND) >> KGAIN_W);
    end
  end

endmodule

// File: rtl/cordic_postproc.sv
// Output stage after the last vectoring CORDIC pipe stage: gain-compensated
// magnitude, unfolded phase and non-convergence flag over a 3-stage enabled pipe.
module cordic_postproc
  import cordic_pkg::*;
#(
  parameter int unsigned        WIDTH   = DEF_WIDTH,
  parameter int unsigned        AWIDTH  = DEF_AWIDTH,
  parameter logic [KGAIN_W-1:0] KGAIN   = DEF_KGAIN,
  parameter int unsigned        RES_TOL = DEF_RES_TOL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  Xi,
  input  logic [WIDTH-1:0]  Yi,
  input  logic [AWIDTH-1:0] Zi,
  input  logic              flip_i,
  output logic              out_valid,
  output logic [WIDTH-1:0]  mag_o,
  output logic [AWIDTH-1:0] phase_o,
  output logic              nconv_o
);

  localparam int unsigned YW = WIDTH + 1;
  localparam logic [AWIDTH-1:0] HALF_TURN = {1'b1, {(AWIDTH-1){1'b0}}};

  logic              v1, v2;
  logic [WIDTH-1:0]  xabs;
  logic [AWIDTH-1:0] ph1, ph2;
  logic              nc1, nc2;
  logic [YW-1:0]     yext_c, yabs_c;

  // |Yi| in WIDTH+1 bits so the most-negative input maps to +2^(WIDTH-1)
  always_comb begin
    yext_c = {Yi[WIDTH-1], Yi};
    yabs_c = yext_c;
    if (Yi[WIDTH-1]) yabs_c = -yext_c;
  end

  // Stage 1: clamp negative X (fault), unfold phase, residual check
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      xabs <= '0;
      ph1  <= '0;
      nc1  <= 1'b0;
    end else if (ena) begin
      v1   <= in_valid;
      xabs <= Xi[WIDTH-1] ? '0 : Xi;
      ph1  <= Zi + (flip_i ? HALF_TURN : '0);
      nc1  <= yabs_c > YW'(RES_TOL);
    end
  end

  // Stages 2-3: valid, phase and flag ride alongside the multiplier
  always_ff @(posedge clk) begin
    if (rst) begin
      v2        <= 1'b0;
      ph2       <= '0;
      nc2       <= 1'b0;
      out_valid <= 1'b0;
      phase_o   <= '0;
      nconv_o   <= 1'b0;
    end else if (ena) begin
      v2        <= v1;
      ph2       <= ph1;
      nc2       <= nc1;
      out_valid <= v2;
      phase_o   <= ph2;
      nconv_o   <= nc2;
    end
  end

  cordic_gain_mult #(
    .WIDTH (WIDTH),
    .KGAIN (KGAIN)
  ) u_gain (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .xabs (xabs),
    .mag  (mag_o)
  );

endmodule

// File: doc/cordic_postproc.md
Name: cordic_postproc

Overview:
- Output stage placed directly after the last vectoring-mode CORDIC pipe stage.
- Consumes the final X, residual Y and accumulated angle Z from that stage.
- Applies CORDIC gain compensation to X to produce the magnitude, and undoes the 180° input fold on Z to produce the phase.
- Flags non-convergence when the residual Y is too large.
- Three-stage enabled pipeline with valid tracking, so downstream logic can consume results directly.

Parameters:
- WIDTH, 16: X/Y data width, two's complement.
- AWIDTH, 20: angle width; full turn = 2^AWIDTH, so 180° = 2^(AWIDTH-1).
- KGAIN, 16'h9B75: 1/CORDIC gain (0.607253) in unsigned Q0.16.
- RES_TOL, 8: maximum |Yi| still counted as converged.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  pipeline advance enable; 0 freezes every register.
- in_valid  in  1  Xi/Yi/Zi/flip_i carry a valid sample.
- Xi  in  WIDTH  final X from the pipe (signed).
- Yi  in  WIDTH  residual Y from the pipe (signed).
- Zi  in  AWIDTH  accumulated angle from the pipe.
- flip_i  in  1  sample was negated (rotated 180°) by the pre-fold; delay-matched upstream.
- out_valid  out  1  mag_o/phase_o/nconv_o valid.
- mag_o  out  WIDTH  gain-compensated magnitude (non-negative).
- phase_o  out  AWIDTH  unfolded phase, modulo 2^AWIDTH.
- nconv_o  out  1  |Yi| > RES_TOL.

Behaviour:
- Reset: on rst=1 at a clock edge, all valid bits and all outputs (out_valid, mag_o, phase_o, nconv_o) go to 0, along with internal stage registers.
  - rst has priority over ena.
  - Reset in mid-flight discards every in-flight sample; no partial result is ever emitted.
- Enable: ena=0 holds all registers, including valid bits and outputs, unchanged.
  - Pipeline advances only on edges where ena=1.
  - in_valid is sampled only when ena=1.
- Latency: exactly 3 enabled edges. A sample accepted on edge k has out_valid=1 after enabled edge k+2 (third enabled edge counting k).
  - Throughput: one sample per enabled cycle.
  - Bubbles (in_valid=0) propagate as out_valid=0. Data registers may still load, but their content is don't-care when invalid.
- Stage 1 (register):
  - xabs = Xi if Xi ≥ 0, else 0. A negative X indicates a fault and is clamped, not negated.
  - ph = Zi + (flip_i ? 2^(AWIDTH-1) : 0), truncated to AWIDTH bits (natural wrap).
  - yabs = |Yi|. The most-negative Yi value is treated as 2^(WIDTH-1), so compute the absolute value in WIDTH+1 bits.
  - nc = (yabs > RES_TOL).
- Stage 2 (register): prod = xabs × KGAIN, unsigned, WIDTH+16 bits. ph, nc and valid pass through.
- Stage 3 (register): mag_o = (prod + 2^15) >> 16, round half up, truncated to WIDTH bits.
  - Cannot overflow because KGAIN < 1; the sign bit of mag_o is always 0.
  - phase_o = ph, nconv_o = nc, out_valid = stage-2 valid.
- No backpressure: the consumer must accept every out_valid=1 cycle. Stalling is done only through ena.

Decomposition:
- Shared cordic package holds:
  - KGAIN;
  - the angle-scale constants ANG_180 = 2^(AWIDTH-1) and ANG_90 = 2^(AWIDTH-2);
  - default WIDTH/AWIDTH, so pre-fold, pipe and post stages agree on angle units (atan(1) = 0x20000 at AWIDTH=20).
- One natural sub-module: cordic_gain_mult, the registered unsigned WIDTH×16 multiply with rounding (stages 2–3).
- The top level holds stage 1 and the valid chain.

Test Plan:
- rst=1 for 2 cycles, then ena=1 with in_valid=0 for 5 cycles → out_valid, mag_o, phase_o, nconv_o all 0 throughout.
- Xi=0x4000, Yi=0, Zi=0x20000, flip_i=0, one valid sample → 3 enabled edges later: out_valid=1 for exactly one cycle, mag_o=0x26DD, phase_o=0x20000, nconv_o=0.
- Xi=0x7FFF, flip_i=1, Zi=0xA0000 → mag_o=0x4DBA, phase_o=0x20000 (wrap). Also Zi=0x20000 with flip_i=1 → phase_o=0xA0000.
- Xi=0x8000 → mag_o=0. Yi=0xFFF0 (−16) → nconv_o=1. Yi=0xFFF8 (−8) → nconv_o=0. Yi=0x8000 → nconv_o=1.
- Back-to-back samples A, B, C with ena deasserted for 2 cycles between B and C → outputs frozen during the stall; A, B, C each emerge exactly once, in order, with 3-enabled-edge latency.
- Two valid samples in flight, then rst pulse for 1 cycle → no out_valid afterwards until a new sample is fed; that sample then emerges after 3 edges.
